// File: rtl/throw_ctl_cat.sv
// throw_ctl_cat - ballistic trajectory generator for the cat's projectile.
//
// A rising edge on fire (accepted only while idle) latches a launch strength
// from the charge meter. The shot is launched on the next frame tick and is
// advanced once per frame until it either lands or leaves the screen. The
// position is presented in the draw stage's frame: x from the right screen
// edge, y from the bottom.
//
// Ports:
//   clk     in   pixel clock
//   rst     in   asynchronous active-high reset
//   vsync   in   VGA vsync (same clock domain), rising edge = frame tick
//   fire    in   launch request, rising-edge sensitive
//   abort   in   level cancel, returns to idle with no event pulse
//   power   in   7-bit charge value, sampled on the accepted fire edge
//   x_pos   out  12-bit projectile x to the draw stage
//   y_pos   out  12-bit projectile y to the draw stage
//   active  out  shot in flight or landed
//   busy    out  any state except idle
//   landed  out  one-cycle pulse on ground contact
//   miss    out  one-cycle pulse when the shot leaves the screen
module throw_ctl_cat #(
    parameter int START_X     = 100,
    parameter int START_Y     = 200,
    parameter int VX_BASE     = 2,
    parameter int VY_BASE     = 8,
    parameter int GRAVITY     = 1,
    parameter int GROUND_Y    = 40,
    parameter int X_LIMIT     = 1100,
    parameter int HOLD_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        fire,
    input  logic        abort,
    input  logic [6:0]  power,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        active,
    output logic        busy,
    output logic        landed,
    output logic        miss
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [12:0]        X_LIM    = 13'(X_LIMIT);
    localparam logic signed [13:0] GND_14   = 14'(GROUND_Y);
    localparam logic [11:0]        GND_12   = 12'(GROUND_Y);
    localparam logic [11:0]        SX_12    = 12'(START_X);
    localparam logic [11:0]        SY_12    = 12'(START_Y);
    localparam logic [7:0]         VXB_8    = 8'(VX_BASE);
    localparam logic [7:0]         VYB_8    = 8'(VY_BASE);
    localparam logic signed [7:0]  GRAV_8   = 8'(GRAVITY);
    localparam logic [HW-1:0]      HOLD_N   = HW'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, ARMED, FLIGHT, LANDED} state_t;

    state_t             state, state_nxt;
    logic               vsync_q, fire_q;
    logic               tick, fire_edge;
    logic [3:0]         pw, pw_nxt;
    logic [7:0]         vx, vx_nxt;
    logic signed [7:0]  vy, vy_nxt;
    logic [HW-1:0]      hold_cnt, hold_nxt, hold_inc;
    logic [11:0]        x_nxt, y_nxt;
    logic               landed_nxt, miss_nxt;
    logic [12:0]        x_sum;
    logic signed [13:0] y_sum;
    logic signed [7:0]  vy_dec;

    assign tick      = vsync & ~vsync_q;
    assign fire_edge = fire & ~fire_q;

    // Candidate next-frame kinematics. y is widened and signed so that a
    // step that would carry the shot below zero still compares as low.
    assign x_sum    = {1'b0, x_pos} + {5'd0, vx};
    assign y_sum    = $signed({2'b00, y_pos}) + $signed({{6{vy[7]}}, vy});
    assign vy_dec   = vy - GRAV_8;
    assign hold_inc = hold_cnt + HW'(1);

    always_comb begin
        state_nxt  = state;
        x_nxt      = x_pos;
        y_nxt      = y_pos;
        vx_nxt     = vx;
        vy_nxt     = vy;
        pw_nxt     = pw;
        hold_nxt   = hold_cnt;
        landed_nxt = 1'b0;
        miss_nxt   = 1'b0;

        // abort overrides any tick or fire seen in the same cycle
        if (abort) begin
            state_nxt = IDLE;
            x_nxt     = '0;
            y_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    x_nxt = '0;
                    y_nxt = '0;
                    if (fire_edge) begin
                        pw_nxt    = power[6:3];
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (tick) begin
                        x_nxt     = SX_12;
                        y_nxt     = SY_12;
                        vx_nxt    = VXB_8 + {4'd0, pw};
                        vy_nxt    = $signed(VYB_8 + {4'd0, pw});
                        state_nxt = FLIGHT;
                    end
                end
                FLIGHT: begin
                    if (tick) begin
                        if (x_sum >= X_LIM) begin
                            miss_nxt  = 1'b1;
                            x_nxt     = '0;
                            y_nxt     = '0;
                            state_nxt = IDLE;
                        end else if (y_sum <= GND_14) begin
                            x_nxt      = x_sum[11:0];
                            y_nxt      = GND_12;
                            landed_nxt = 1'b1;
                            hold_nxt   = '0;
                            state_nxt  = LANDED;
                        end else begin
                            x_nxt  = x_sum[11:0];
                            y_nxt  = y_sum[11:0];
                            vy_nxt = vy_dec;
                        end
                    end
                end
                LANDED: begin
                    if (tick) begin
                        hold_nxt = hold_inc;
                        if (hold_inc == HOLD_N) begin
                            x_nxt     = '0;
                            y_nxt     = '0;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    x_nxt     = '0;
                    y_nxt     = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vsync_q  <= 1'b0;
            fire_q   <= 1'b0;
            pw       <= '0;
            vx       <= '0;
            vy       <= '0;
            hold_cnt <= '0;
            x_pos    <= '0;
            y_pos    <= '0;
            active   <= 1'b0;
            busy     <= 1'b0;
            landed   <= 1'b0;
            miss     <= 1'b0;
        end else begin
            state    <= state_nxt;
            vsync_q  <= vsync;
            fire_q   <= fire;
            pw       <= pw_nxt;
            vx       <= vx_nxt;
            vy       <= vy_nxt;
            hold_cnt <= hold_nxt;
            x_pos    <= x_nxt;
            y_pos    <= y_nxt;
            active   <= (state_nxt == FLIGHT) || (state_nxt == LANDED);
            busy     <= (state_nxt != IDLE);
            landed   <= landed_nxt;
            miss     <= miss_nxt;
        end
    end

endmodule
